// File: rtl/vtx_pkg.sv
// Shared FSM state encoding and default sizing for the coprocessor-register tracker.
package vtx_pkg;

  localparam int VTX_NREGS   = 16;
  localparam int VTX_XLEN    = 32;
  localparam int VTX_NWP     = 2;
  localparam int VTX_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } vtx_state_e;

endpackage

// File: rtl/vtx_shadow_rf.sv
// Purpose: shadow copy of the coprocessor register file, fed by every write port.
// Latency: rf_cur is the registered value, rf_nxt is this cycle's post-write view.
// Backpressure: none; writes are observed, never stalled.
module vtx_shadow_rf #(
  parameter int NREGS = vtx_pkg::VTX_NREGS,
  parameter int XLEN  = vtx_pkg::VTX_XLEN,
  parameter int NWP   = vtx_pkg::VTX_NWP,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  vtx_clk,
  input  logic                  vtx_reset,
  input  logic [NWP-1:0]        wr_en,
  input  logic [NWP*AW-1:0]     wr_addr,
  input  logic [NWP*XLEN-1:0]   wr_data,
  output logic [NREGS*XLEN-1:0] rf_cur,
  output logic [NREGS*XLEN-1:0] rf_nxt
);

  // Later ports overwrite earlier ones, so the highest index wins a conflict.
  always_comb begin
    rf_nxt = rf_cur;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
          rf_nxt[r*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      rf_cur <= '0;
    end else begin
      rf_cur <= rf_nxt;
    end
  end

endmodule

// File: rtl/vtx_cpr_tracker.sv
// Purpose: capture issue/retire records with pre/post coprocessor register snapshots.
// Latency: vtx_valid pulses the cycle after ret_valid is sampled; timeout after TIMEOUT active cycles.
// Backpressure: none; illegal issue/retire strobes are dropped and flagged in vtx_proto_err.
module vtx_cpr_tracker
  import vtx_pkg::*;
#(
  parameter int NREGS   = VTX_NREGS,
  parameter int XLEN    = VTX_XLEN,
  parameter int NWP     = VTX_NWP,
  parameter int TIMEOUT = VTX_TIMEOUT,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  vtx_clk,
  input  logic                  vtx_reset,
  input  logic                  issue_valid,
  input  logic [31:0]           issue_enc,
  input  logic [XLEN-1:0]       issue_rs1,
  input  logic [NWP-1:0]        wr_en,
  input  logic [NWP*AW-1:0]     wr_addr,
  input  logic [NWP*XLEN-1:0]   wr_data,
  input  logic                  ret_valid,
  input  logic [2:0]            ret_result,
  input  logic [XLEN-1:0]       ret_wdata,
  input  logic [4:0]            ret_waddr,
  input  logic                  ret_wen,
  output logic                  vtx_valid,
  output logic [31:0]           vtx_instr_enc,
  output logic [XLEN-1:0]       vtx_instr_rs1,
  output logic [2:0]            vtx_instr_result,
  output logic [XLEN-1:0]       vtx_instr_wdata,
  output logic [4:0]            vtx_instr_waddr,
  output logic                  vtx_instr_wen,
  output logic [NREGS*XLEN-1:0] vtx_cprs_pre,
  output logic [NREGS*XLEN-1:0] vtx_cprs_post,
  output logic                  vtx_timeout,
  output logic                  vtx_proto_err,
  output logic                  busy
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  vtx_state_e state_q, state_d;

  logic [NREGS*XLEN-1:0] rf_cur, rf_nxt;
  logic [15:0]           cnt_q;
  logic [31:0]           pend_enc;
  logic [XLEN-1:0]       pend_rs1;
  logic [NREGS*XLEN-1:0] pend_pre;

  logic pend_ld, rec_ld_issue, rec_ld_pend, to_set, err_set, cnt_clr, cnt_inc;

  vtx_shadow_rf #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .NWP   (NWP)
  ) u_shadow (
    .vtx_clk   (vtx_clk),
    .vtx_reset (vtx_reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rf_cur    (rf_cur),
    .rf_nxt    (rf_nxt)
  );

  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_ld      = 1'b0;
    rec_ld_issue = 1'b0;
    rec_ld_pend  = 1'b0;
    to_set       = 1'b0;
    err_set      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          cnt_clr = 1'b1;
          if (ret_valid) begin
            state_d      = ST_REPORT;
            rec_ld_issue = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
            pend_ld = 1'b1;
          end
        end else if (ret_valid) begin
          err_set = 1'b1;
        end
      end
      ST_ACTIVE: begin
        err_set = issue_valid;
        // A retire on the last allowed cycle still wins over the abandon.
        if (ret_valid) begin
          state_d     = ST_REPORT;
          rec_ld_pend = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          to_set  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_REPORT: begin
        err_set = issue_valid;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue-time capture is staged so the visible record only changes on entry to REPORT.
  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      cnt_q            <= '0;
      pend_enc         <= '0;
      pend_rs1         <= '0;
      pend_pre         <= '0;
      vtx_instr_enc    <= '0;
      vtx_instr_rs1    <= '0;
      vtx_instr_result <= '0;
      vtx_instr_wdata  <= '0;
      vtx_instr_waddr  <= '0;
      vtx_instr_wen    <= 1'b0;
      vtx_cprs_pre     <= '0;
      vtx_cprs_post    <= '0;
      vtx_timeout      <= 1'b0;
      vtx_proto_err    <= 1'b0;
    end else begin
      vtx_timeout <= to_set;
      if (err_set) vtx_proto_err <= 1'b1;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (pend_ld) begin
        pend_enc <= issue_enc;
        pend_rs1 <= issue_rs1;
        pend_pre <= rf_cur;
      end
      if (rec_ld_issue || rec_ld_pend) begin
        vtx_instr_enc    <= rec_ld_issue ? issue_enc : pend_enc;
        vtx_instr_rs1    <= rec_ld_issue ? issue_rs1 : pend_rs1;
        vtx_cprs_pre     <= rec_ld_issue ? rf_cur    : pend_pre;
        vtx_cprs_post    <= rf_nxt;
        vtx_instr_result <= ret_result;
        vtx_instr_wdata  <= ret_wdata;
        vtx_instr_waddr  <= ret_waddr;
        vtx_instr_wen    <= ret_wen;
      end
    end
  end

  assign vtx_valid = (state_q == ST_REPORT);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vtx_cpr_tracker.sv
// Self-checking bench for vtx_cpr_tracker: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_vtx_cpr_tracker;

  localparam int NREGS = 16;
  localparam int XLEN  = 32;
  localparam int NWP   = 2;
  localparam int TO    = 4;
  localparam int AW    = $clog2(NREGS);
  localparam int W     = NREGS * XLEN;

  typedef logic [XLEN-1:0] rf_t [NREGS];

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issue_valid;
  logic [31:0]           issue_enc;
  logic [XLEN-1:0]       issue_rs1;
  logic [NWP-1:0]        wr_en;
  logic [NWP*AW-1:0]     wr_addr;
  logic [NWP*XLEN-1:0]   wr_data;
  logic                  ret_valid;
  logic [2:0]            ret_result;
  logic [XLEN-1:0]       ret_wdata;
  logic [4:0]            ret_waddr;
  logic                  ret_wen;
  logic                  vtx_valid;
  logic [31:0]           vtx_instr_enc;
  logic [XLEN-1:0]       vtx_instr_rs1;
  logic [2:0]            vtx_instr_result;
  logic [XLEN-1:0]       vtx_instr_wdata;
  logic [4:0]            vtx_instr_waddr;
  logic                  vtx_instr_wen;
  logic [W-1:0]          vtx_cprs_pre;
  logic [W-1:0]          vtx_cprs_post;
  logic                  vtx_timeout;
  logic                  vtx_proto_err;
  logic                  busy;

  always #5 clk = ~clk;

  vtx_cpr_tracker #(
    .NREGS   (NREGS),
    .XLEN    (XLEN),
    .NWP     (NWP),
    .TIMEOUT (TO)
  ) dut (
    .vtx_clk          (clk),
    .vtx_reset        (rst),
    .issue_valid      (issue_valid),
    .issue_enc        (issue_enc),
    .issue_rs1        (issue_rs1),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .ret_valid        (ret_valid),
    .ret_result       (ret_result),
    .ret_wdata        (ret_wdata),
    .ret_waddr        (ret_waddr),
    .ret_wen          (ret_wen),
    .vtx_valid        (vtx_valid),
    .vtx_instr_enc    (vtx_instr_enc),
    .vtx_instr_rs1    (vtx_instr_rs1),
    .vtx_instr_result (vtx_instr_result),
    .vtx_instr_wdata  (vtx_instr_wdata),
    .vtx_instr_waddr  (vtx_instr_waddr),
    .vtx_instr_wen    (vtx_instr_wen),
    .vtx_cprs_pre     (vtx_cprs_pre),
    .vtx_cprs_post    (vtx_cprs_post),
    .vtx_timeout      (vtx_timeout),
    .vtx_proto_err    (vtx_proto_err),
    .busy             (busy)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] flat(input rf_t a);
    logic [W-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r*XLEN +: XLEN] = a[r];
    return v;
  endfunction

  function automatic logic [XLEN-1:0] fld(input logic [W-1:0] v, input int r);
    return v[r*XLEN +: XLEN];
  endfunction

  // Reference model: tracks the one in-flight instruction as a transaction,
  // timing out when TO clock edges have passed since its issue edge.
  int              cyc = 0;
  int              issue_cyc = 0;
  bit              inflight = 1'b0;
  bit              reporting = 1'b0;
  logic [31:0]     p_enc;
  logic [XLEN-1:0] p_rs1;
  rf_t             p_pre, m_rf, m_nx;
  logic            e_timeout, e_err;
  logic [31:0]     e_enc;
  logic [XLEN-1:0] e_rs1, e_wdata;
  logic [2:0]      e_result;
  logic [4:0]      e_waddr;
  logic            e_wen;
  rf_t             e_pre, e_post;

  always @(posedge clk) begin
    cyc++;
    m_nx = m_rf;
    for (int p = 0; p < NWP; p++)
      if (wr_en[p]) m_nx[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
    e_timeout = 1'b0;
    if (rst) begin
      inflight = 1'b0; reporting = 1'b0; e_err = 1'b0;
      e_enc = '0; e_rs1 = '0; e_wdata = '0; e_result = '0; e_waddr = '0; e_wen = 1'b0;
      p_enc = '0; p_rs1 = '0;
      for (int r = 0; r < NREGS; r++) begin
        m_rf[r] = '0; e_pre[r] = '0; e_post[r] = '0; p_pre[r] = '0;
      end
    end else begin
      if (reporting) begin
        reporting = 1'b0;
        if (issue_valid) e_err = 1'b1;
      end else if (inflight) begin
        if (issue_valid) e_err = 1'b1;
        if (ret_valid) begin
          e_enc = p_enc; e_rs1 = p_rs1; e_pre = p_pre; e_post = m_nx;
          e_result = ret_result; e_wdata = ret_wdata; e_waddr = ret_waddr; e_wen = ret_wen;
          inflight = 1'b0; reporting = 1'b1;
        end else if (cyc - issue_cyc == TO) begin
          inflight = 1'b0; e_timeout = 1'b1;
        end
      end else if (issue_valid) begin
        if (ret_valid) begin
          e_enc = issue_enc; e_rs1 = issue_rs1; e_pre = m_rf; e_post = m_nx;
          e_result = ret_result; e_wdata = ret_wdata; e_waddr = ret_waddr; e_wen = ret_wen;
          reporting = 1'b1;
        end else begin
          p_enc = issue_enc; p_rs1 = issue_rs1; p_pre = m_rf;
          issue_cyc = cyc; inflight = 1'b1;
        end
      end else if (ret_valid) begin
        e_err = 1'b1;
      end
      m_rf = m_nx;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",   W'(vtx_valid),        W'(reporting));
      check("busy",    W'(busy),             W'(inflight | reporting));
      check("timeout", W'(vtx_timeout),      W'(e_timeout));
      check("perr",    W'(vtx_proto_err),    W'(e_err));
      check("enc",     W'(vtx_instr_enc),    W'(e_enc));
      check("rs1",     W'(vtx_instr_rs1),    W'(e_rs1));
      check("result",  W'(vtx_instr_result), W'(e_result));
      check("wdata",   W'(vtx_instr_wdata),  W'(e_wdata));
      check("waddr",   W'(vtx_instr_waddr),  W'(e_waddr));
      check("wen",     W'(vtx_instr_wen),    W'(e_wen));
      check("pre",     vtx_cprs_pre,         flat(e_pre));
      check("post",    vtx_cprs_post,        flat(e_post));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n_vec++;
  endtask

  task automatic quiet();
    issue_valid = 1'b0; issue_enc = '0; issue_rs1 = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    ret_valid = 1'b0; ret_result = '0; ret_wdata = '0; ret_waddr = '0; ret_wen = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", W'(vtx_valid), W'(0));
    check("rst_busy",  W'(busy), W'(0));
    check("rst_perr",  W'(vtx_proto_err), W'(0));
    check("rst_pre",   vtx_cprs_pre, W'(0));

    // Issue, writes in flight, retire one cycle later.
    wr(0, 3, 32'hA5A5A5A5); tick(); quiet();
    issue_valid = 1'b1; issue_enc = 32'h0000000B; issue_rs1 = 32'h1234; tick(); quiet();
    check("act_busy", W'(busy), W'(1));
    wr(1, 3, 32'h5);
    ret_valid = 1'b1; ret_result = 3'b101; ret_wdata = 32'hCAFE; ret_waddr = 5'd9; ret_wen = 1'b1;
    tick(); quiet();
    check("r35_valid", W'(vtx_valid), W'(1));
    check("r35_enc",   W'(vtx_instr_enc), W'(32'hB));
    check("r35_pre3",  W'(fld(vtx_cprs_pre, 3)), W'(32'hA5A5A5A5));
    check("r35_post3", W'(fld(vtx_cprs_post, 3)), W'(32'h5));
    check("r35_waddr", W'(vtx_instr_waddr), W'(5'd9));
    tick();
    check("r35_drop",  W'(vtx_valid), W'(0));
    check("r35_hold",  W'(vtx_instr_enc), W'(32'hB));

    // Same-address conflict resolves to the higher port.
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); tick(); quiet();
    issue_valid = 1'b1; ret_valid = 1'b1; tick(); quiet();
    check("r36_r7", W'(fld(vtx_cprs_post, 7)), W'(32'h22));
    tick();

    // Single-cycle instruction.
    issue_valid = 1'b1; ret_valid = 1'b1; issue_enc = 32'h77; wr(0, 0, 32'h1); tick(); quiet();
    check("r37_valid", W'(vtx_valid), W'(1));
    check("r37_pre0",  W'(fld(vtx_cprs_pre, 0)), W'(0));
    check("r37_post0", W'(fld(vtx_cprs_post, 0)), W'(32'h1));
    tick();

    // Abandon after TO active cycles.
    issue_valid = 1'b1; issue_enc = 32'h99; tick(); quiet();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("r38_early", W'(vtx_timeout), W'(0));
    end
    tick();
    check("r38_to",    W'(vtx_timeout), W'(1));
    check("r38_busy",  W'(busy), W'(0));
    check("r38_valid", W'(vtx_valid), W'(0));
    check("r38_perr",  W'(vtx_proto_err), W'(0));
    tick();
    check("r38_pulse", W'(vtx_timeout), W'(0));

    // Retire on the abandon cycle still reports.
    issue_valid = 1'b1; tick(); quiet();
    repeat (TO - 1) tick();
    ret_valid = 1'b1; tick(); quiet();
    check("r30_valid", W'(vtx_valid), W'(1));
    check("r30_to",    W'(vtx_timeout), W'(0));
    tick();

    // Second issue while active.
    issue_valid = 1'b1; issue_enc = 32'h111; tick();
    issue_enc = 32'h222; tick(); quiet();
    check("r39_perr", W'(vtx_proto_err), W'(1));
    ret_valid = 1'b1; tick(); quiet();
    check("r39_valid", W'(vtx_valid), W'(1));
    check("r39_enc",   W'(vtx_instr_enc), W'(32'h111));
    tick();
    check("r39_sticky", W'(vtx_proto_err), W'(1));

    // Reset mid-flight, writes during reset ignored, then an orphan retire.
    issue_valid = 1'b1; tick(); quiet();
    rst = 1'b1; wr(0, 5, 32'hDEAD); tick(); quiet();
    rst = 1'b0; ret_valid = 1'b1; tick(); quiet();
    check("r40_valid", W'(vtx_valid), W'(0));
    check("r40_perr",  W'(vtx_proto_err), W'(1));
    check("r40_pre",   vtx_cprs_pre, W'(0));
    check("r40_post",  vtx_cprs_post, W'(0));
    issue_valid = 1'b1; ret_valid = 1'b1; tick(); quiet();
    check("r32_pre",   vtx_cprs_pre, W'(0));
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      issue_valid = ($urandom_range(0, 99) < 25);
      ret_valid   = ($urandom_range(0, 99) < 30);
      issue_enc   = $urandom;
      issue_rs1   = $urandom;
      wr_en       = NWP'($urandom);
      wr_addr     = (NWP*AW)'($urandom);
      wr_data     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
      ret_result  = 3'($urandom);
      ret_wdata   = $urandom;
      ret_waddr   = 5'($urandom);
      ret_wen     = 1'($urandom);
      tick();
    end
    rst = 1'b0; quiet();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
